spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_fifo.sv | 67 ++++++
 rtl/spi_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: register offsets, STATUS/CTRL bit
// positions and the shift-engine state encoding.
package spi_pkg;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;
    localparam logic [1:0] ADR_CLKDIV = 2'd3;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_RX_EMPTY = 1;
    localparam int STAT_TX_FULL  = 2;
    localparam int STAT_BUSY     = 3;
    localparam int STAT_RX_OVF   = 4;
    localparam int STAT_TX_OVF   = 5;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_SS_FORCE = 1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with power-of-two depth, wrapping pointers and an
// occupancy counter one bit wider than the pointers.
module spi_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    // A full FIFO still takes a push alongside a pop; the slot being freed is the one written.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 MSB first, with a four-register MMIO file and TX/RX byte FIFOs.
//
// state    | meaning
// IDLE     | waiting for en and a byte in TX
// LOAD     | pop TX head into shift register, bit count = 8
// SHIFT_LO | sck low, mosi = shift[7]; sample miso at end of half-period
// SHIFT_HI | sck high; shift sample in at end of half-period, count down
// DONE     | push received byte to RX (or flag rx_ovf), chain or stop
module spi_master
    import spi_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RESET  = 8'd7
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       cs,
    input  logic [1:0] adr,
    input  logic       wren,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ss_n
);

    spi_state_e state_q, state_d;
    logic       cs_q;
    logic       en_q, en_d;
    logic       ss_force_q, ss_force_d;
    logic [7:0] clkdiv_q, clkdiv_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic       rx_ovf_q, rx_ovf_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sample_q, sample_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       ss_n_q, ss_n_d;

    logic       access, wr_acc, rd_acc, busy;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic [7:0] status, rdata;

    // Only the first cycle of a bus access acts, however long cs is held.
    assign access = cs & ~cs_q;
    assign wr_acc = access & wren;
    assign rd_acc = access & ~wren;
    assign busy   = (state_q != ST_IDLE);

    assign tx_push = wr_acc & (adr == ADR_DATA);
    assign tx_pop  = (state_q == ST_LOAD);
    assign rx_push = (state_q == ST_DONE);
    assign rx_pop  = rd_acc & (adr == ADR_DATA);

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk    (clk),
        .n_reset(n_reset),
        .push   (tx_push),
        .pop    (tx_pop),
        .wdata  (di),
        .head   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk    (clk),
        .n_reset(n_reset),
        .push   (rx_push),
        .pop    (rx_pop),
        .wdata  (shift_q),
        .head   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    always_comb begin
        status                = '0;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_BUSY]     = busy;
        status[STAT_RX_OVF]   = rx_ovf_q;
        status[STAT_TX_OVF]   = tx_ovf_q;
    end

    always_comb begin
        rdata = '0;
        case (adr)
            ADR_DATA:   rdata = rx_empty ? 8'h00 : rx_head;
            ADR_STATUS: rdata = status;
            ADR_CTRL:   rdata = {6'b0, ss_force_q, en_q};
            ADR_CLKDIV: rdata = clkdiv_q;
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        en_d       = en_q;
        ss_force_d = ss_force_q;
        clkdiv_d   = clkdiv_q;
        tx_ovf_d   = tx_ovf_q;
        rx_ovf_d   = rx_ovf_q;
        dout_d     = dout_q;
        if (wr_acc && adr == ADR_CTRL) begin
            en_d       = di[CTRL_EN];
            ss_force_d = di[CTRL_SS_FORCE];
        end
        if (wr_acc && adr == ADR_CLKDIV) begin
            clkdiv_d = di;
        end
        if (rd_acc && adr == ADR_STATUS) begin
            tx_ovf_d = 1'b0;
            rx_ovf_d = 1'b0;
        end
        // New overflow events win over a same-cycle STATUS read clear.
        if (tx_push && tx_full && !tx_pop) begin
            tx_ovf_d = 1'b1;
        end
        if (rx_push && rx_full && !rx_pop) begin
            rx_ovf_d = 1'b1;
        end
        if (!cs) begin
            dout_d = 8'h00;
        end else if (access) begin
            dout_d = rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sample_d  = sample_q;
        case (state_q)
            ST_IDLE: begin
                if (en_q && !tx_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d   = tx_head;
                bit_cnt_d = BITS_PER_BYTE;
                div_cnt_d = clkdiv_q;
                state_d   = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (div_cnt_q == '0) begin
                    sample_d  = miso;
                    div_cnt_d = clkdiv_q;
                    state_d   = ST_SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (div_cnt_q == '0) begin
                    shift_d   = {shift_q[6:0], sample_q};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    div_cnt_d = clkdiv_q;
                    state_d   = (bit_cnt_q == 4'd1) ? ST_DONE : ST_SHIFT_LO;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = (en_q && !tx_empty) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin drivers are registered from next-state so they are glitch-free and aligned with state_q.
        sck_d  = (state_d == ST_SHIFT_HI);
        mosi_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) & shift_d[7];
        ss_n_d = ~(ss_force_d | (state_d != ST_IDLE));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b0;
            en_q       <= 1'b0;
            ss_force_q <= 1'b0;
            clkdiv_q   <= DIV_RESET;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            dout_q     <= 8'h00;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sample_q   <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs;
            en_q       <= en_d;
            ss_force_q <= ss_force_d;
            clkdiv_q   <= clkdiv_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            dout_q     <= dout_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign dout = dout_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign ss_n = ss_n_q;

endmodule
